branch_resolve: RTL

Branch resolution and predictor-training unit, the consumer end of the fetch-stage branch predictor. Every fetch-stage prediction is recorded in a small in-order queue. When execute reports the real outcome of a branch, the unit compares it with the oldest queued prediction and does three things: issues a redirect and flush to pc_reg on a mispredict, emits one training update back to the predictor, and keeps performance counters.

---
 rtl/branch_resolve.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/branch_resolve.sv
// Branch resolution unit: queues fetch-stage predictions in order, checks them
// against execute outcomes, and produces redirect/flush, predictor training and counters.
module branch_resolve #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pre_valid_i,
   input  logic [31:0] pre_pc_i,
   input  logic        pre_take_or_not_i,
   input  logic        pre_sel_i,
   input  logic [31:0] pre_target_i,
   output logic        full_o,
   input  logic        ex_valid_i,
   input  logic [31:0] ex_pc_i,
   input  logic        ex_taken_i,
   input  logic [31:0] ex_target_i,
   output logic        redirect_o,
   output logic [31:0] redirect_addr_o,
   output logic        flush_o,
   output logic        upd_valid_o,
   output logic [31:0] upd_pc_o,
   output logic        upd_taken_o,
   output logic        upd_correct_o,
   output logic        upd_sel_o,
   output logic [31:0] branch_cnt_o,
   output logic [31:0] mispred_cnt_o,
   output logic        err_o
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   typedef struct packed {
      logic [31:0] pc;
      logic        dir;
      logic        sel;
      logic [31:0] tgt;
   } rec_t;

   rec_t [DEPTH-1:0] mem_q, mem_d;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]      cnt_q, cnt_d;
   logic             redirect_q, redirect_d;
   logic [31:0]      redirect_addr_q, redirect_addr_d;
   logic             upd_valid_q, upd_valid_d;
   logic [31:0]      upd_pc_q, upd_pc_d;
   logic             upd_taken_q, upd_taken_d;
   logic             upd_correct_q, upd_correct_d;
   logic             upd_sel_q, upd_sel_d;
   logic [31:0]      branch_cnt_q, branch_cnt_d;
   logic [31:0]      mispred_cnt_q, mispred_cnt_d;
   logic             err_q, err_d;

   rec_t        head_s;
   logic        full_s, match_s, mispred_s, flush_s, pop_s, push_s;
   logic [31:0] actual_next_s;

   // Resolve decision: compare the oldest prediction with the execute outcome.
   always_comb begin
      head_s        = mem_q[rd_ptr_q];
      full_s        = (cnt_q == FULL_CNT);
      actual_next_s = ex_taken_i ? ex_target_i : (ex_pc_i + 32'd4);
      match_s       = ex_valid_i && (cnt_q != {(AW+1){1'b0}}) && (head_s.pc == ex_pc_i);
      mispred_s     = (head_s.dir != ex_taken_i) || (ex_taken_i && (head_s.tgt != ex_target_i));
      flush_s       = ex_valid_i && (!match_s || mispred_s);
      pop_s         = match_s && !mispred_s;
      push_s        = pre_valid_i && !full_s && !flush_s;
   end

   // Queue next state; a flush drops every record, including a same-cycle push.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (flush_s) begin
         wr_ptr_d = {AW{1'b0}};
         rd_ptr_d = {AW{1'b0}};
         cnt_d    = {(AW+1){1'b0}};
      end else begin
         if (push_s) begin
            mem_d[wr_ptr_q] = '{pc: pre_pc_i, dir: pre_take_or_not_i, sel: pre_sel_i, tgt: pre_target_i};
            wr_ptr_d        = wr_ptr_q + AW'(1'b1);
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1'b1);
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         case ({push_s, pop_s})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1'b1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1'b1);
            default: cnt_d = cnt_q;
         endcase
      end
   end

   // Next values of the registered pulses, counters and sticky error.
   always_comb begin
      upd_valid_d     = match_s;
      upd_pc_d        = match_s ? ex_pc_i : 32'd0;
      upd_taken_d     = match_s && ex_taken_i;
      upd_correct_d   = match_s && !mispred_s;
      upd_sel_d       = match_s && head_s.sel;
      redirect_d      = flush_s;
      redirect_addr_d = flush_s ? actual_next_s : redirect_addr_q;
      branch_cnt_d    = branch_cnt_q + {31'd0, match_s};
      mispred_cnt_d   = mispred_cnt_q + {31'd0, match_s && mispred_s};
      err_d           = err_q || (ex_valid_i && !match_s) || (pre_valid_i && full_s && !flush_s);
   end

   // State registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_q           <= '0;
         wr_ptr_q        <= {AW{1'b0}};
         rd_ptr_q        <= {AW{1'b0}};
         cnt_q           <= {(AW+1){1'b0}};
         redirect_q      <= 1'b0;
         redirect_addr_q <= 32'd0;
         upd_valid_q     <= 1'b0;
         upd_pc_q        <= 32'd0;
         upd_taken_q     <= 1'b0;
         upd_correct_q   <= 1'b0;
         upd_sel_q       <= 1'b0;
         branch_cnt_q    <= 32'd0;
         mispred_cnt_q   <= 32'd0;
         err_q           <= 1'b0;
      end else begin
         mem_q           <= mem_d;
         wr_ptr_q        <= wr_ptr_d;
         rd_ptr_q        <= rd_ptr_d;
         cnt_q           <= cnt_d;
         redirect_q      <= redirect_d;
         redirect_addr_q <= redirect_addr_d;
         upd_valid_q     <= upd_valid_d;
         upd_pc_q        <= upd_pc_d;
         upd_taken_q     <= upd_taken_d;
         upd_correct_q   <= upd_correct_d;
         upd_sel_q       <= upd_sel_d;
         branch_cnt_q    <= branch_cnt_d;
         mispred_cnt_q   <= mispred_cnt_d;
         err_q           <= err_d;
      end
   end

   assign full_o          = (cnt_q == FULL_CNT);
   assign redirect_o      = redirect_q;
   assign flush_o         = redirect_q;
   assign redirect_addr_o = redirect_addr_q;
   assign upd_valid_o     = upd_valid_q;
   assign upd_pc_o        = upd_pc_q;
   assign upd_taken_o     = upd_taken_q;
   assign upd_correct_o   = upd_correct_q;
   assign upd_sel_o       = upd_sel_q;
   assign branch_cnt_o    = branch_cnt_q;
   assign mispred_cnt_o   = mispred_cnt_q;
   assign err_o           = err_q;
endmodule
